// File: rtl/cu_microsequencer_if.sv
// cu_microsequencer_if
//   Bundles the sequencer's memory handshake, decoder-facing inputs and
//   datapath-facing outputs so the sequencer and its environment share one port.
//   master : the sequencer (consumes handshake/decoder inputs, drives control outputs)
//   slave  : the surrounding fetch/decode/datapath environment
// Signals
//   mem_ready     memory completes the current fetch/data access this cycle
//   if_cw         fetch control word
//   ex_cw         decoder control word for the current step
//   ex_kind       00 single, 01 iterate, 10 memory, 11 illegal (as 00)
//   ex_iters      total EX steps for iterate kind
//   halt_req      stop at the next instruction boundary
//   control_word  word driven to the datapath
//   state         IF=0 EX0=1 EXN=2 MEMW=3 HALT=7
//   step          EX step index fed back to the decoder
//   instr_done    pulse on the last cycle of an instruction
//   busy          state != IF
//   timeout_err   sticky memory-wait timeout fault
interface cu_microsequencer_if #(
  parameter int CW_WIDTH = 40,
  parameter int CNT_W    = 7
);
  logic                mem_ready;
  logic [CW_WIDTH-1:0] if_cw;
  logic [CW_WIDTH-1:0] ex_cw;
  logic [1:0]          ex_kind;
  logic [CNT_W-1:0]    ex_iters;
  logic                halt_req;
  logic [CW_WIDTH-1:0] control_word;
  logic [2:0]          state;
  logic [CNT_W-1:0]    step;
  logic                instr_done;
  logic                busy;
  logic                timeout_err;

  modport master (
    input  mem_ready, if_cw, ex_cw, ex_kind, ex_iters, halt_req,
    output control_word, state, step, instr_done, busy, timeout_err
  );

  modport slave (
    output mem_ready, if_cw, ex_cw, ex_kind, ex_iters, halt_req,
    input  control_word, state, step, instr_done, busy, timeout_err
  );
endinterface

// File: rtl/cu_microsequencer.sv
// cu_microsequencer
//   Multi-cycle sequencer for the LEGv8 control unit. Chooses between the fetch
//   control word and the decoder control word each cycle, runs iterated EX steps
//   through a step counter, stretches memory accesses with a ready/wait handshake,
//   faults to HALT on a wait timeout and halts at instruction boundaries on request.
// Ports
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   bus    cu_microsequencer_if.master (handshake, decoder inputs, datapath outputs)
module cu_microsequencer #(
  parameter int CW_WIDTH    = 40,
  parameter int CNT_W       = 7,
  parameter int IL_BIT      = 24,
  parameter int MW_BIT      = 16,
  parameter int RW_BIT      = 15,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  cu_microsequencer_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_EX0  = 3'd1,
    ST_EXN  = 3'd2,
    ST_MEMW = 3'd3,
    ST_HALT = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]    iters_q, iters_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic [CW_WIDTH-1:0] cw;
  logic                done;
  logic                at_limit;

  assign at_limit = (wait_q == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IF;
      step_q    <= '0;
      iters_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      iters_q   <= iters_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    iters_d   = iters_q;
    // Any completed access ends the current wait window.
    wait_d    = bus.mem_ready ? '0 : wait_q;
    timeout_d = timeout_q;
    cw        = '0;
    done      = 1'b0;

    case (state_q)
      ST_IF: begin
        cw = bus.if_cw;
        // A halt request wins over the fetch, so the instruction is not loaded.
        if (bus.halt_req) begin
          cw[IL_BIT] = 1'b0;
          state_d    = ST_HALT;
        end else if (bus.mem_ready) begin
          state_d = ST_EX0;
        end else begin
          cw[IL_BIT] = 1'b0;
          if (at_limit) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      ST_EX0: begin
        cw = bus.ex_cw;
        case (bus.ex_kind)
          2'b01: begin
            iters_d = (bus.ex_iters == '0) ? CNT_W'(1) : bus.ex_iters;
            if (bus.ex_iters <= CNT_W'(1)) begin
              done    = 1'b1;
              state_d = ST_IF;
            end else begin
              step_d  = CNT_W'(1);
              state_d = ST_EXN;
            end
          end
          2'b10: begin
            if (bus.mem_ready) begin
              done    = 1'b1;
              state_d = ST_IF;
            end else begin
              // Register write waits for the data; the memory write strobe stays asserted.
              cw[RW_BIT] = 1'b0;
              cw[MW_BIT] = bus.ex_cw[MW_BIT];
              wait_d     = WAIT_W'(1);
              state_d    = ST_MEMW;
            end
          end
          default: begin
            done    = 1'b1;
            state_d = ST_IF;
          end
        endcase
      end

      ST_EXN: begin
        cw = bus.ex_cw;
        if (step_q == iters_q - CNT_W'(1)) begin
          done    = 1'b1;
          step_d  = '0;
          state_d = ST_IF;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end

      ST_MEMW: begin
        cw = bus.ex_cw;
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = ST_IF;
        end else begin
          cw[RW_BIT] = 1'b0;
          if (at_limit) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      ST_HALT: begin
        cw = '0;
      end

      default: begin
        cw      = '0;
        state_d = ST_IF;
      end
    endcase

    // While reset is held the fetch must not load an instruction.
    if (!reset) begin
      cw[IL_BIT] = 1'b0;
      done       = 1'b0;
    end
  end

  assign bus.control_word = cw;
  assign bus.state        = state_q;
  assign bus.step         = step_q;
  assign bus.instr_done   = done;
  assign bus.busy         = (state_q != ST_IF);
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_cu_microsequencer.sv
// tb_cu_microsequencer
//   Self-checking bench for cu_microsequencer. Each instruction is described at
//   the instruction level (kind, iteration count, fetch latency, memory latency)
//   and expanded into an expected per-cycle trace that is compared with the DUT.
module tb_cu_microsequencer;

  localparam int CW_WIDTH    = 40;
  localparam int CNT_W       = 7;
  localparam int IL_BIT      = 24;
  localparam int MW_BIT      = 16;
  localparam int RW_BIT      = 15;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_EX0  = 3'd1;
  localparam logic [2:0] S_EXN  = 3'd2;
  localparam logic [2:0] S_MEMW = 3'd3;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam logic [CW_WIDTH-1:0] IL_MASK = CW_WIDTH'(1) << IL_BIT;
  localparam logic [CW_WIDTH-1:0] RW_MASK = CW_WIDTH'(1) << RW_BIT;

  logic clock = 1'b0;
  logic reset;
  logic rstLevel;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [CW_WIDTH-1:0] lastIf;

  always #5 clock = ~clock;

  cu_microsequencer_if #(.CW_WIDTH(CW_WIDTH), .CNT_W(CNT_W)) bus ();

  cu_microsequencer #(
    .CW_WIDTH(CW_WIDTH), .CNT_W(CNT_W), .IL_BIT(IL_BIT),
    .MW_BIT(MW_BIT), .RW_BIT(RW_BIT), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [CW_WIDTH-1:0] randCw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CW_WIDTH-1:0];
  endfunction

  task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic ready, input logic [CW_WIDTH-1:0] ifc,
                               input logic [CW_WIDTH-1:0] exc, input logic [1:0] kind,
                               input logic [CNT_W-1:0] iters, input logic halt);
    @(negedge clock);
    reset        = rstLevel;
    bus.mem_ready = ready;
    bus.if_cw    = ifc;
    bus.ex_cw    = exc;
    bus.ex_kind  = kind;
    bus.ex_iters = iters;
    bus.halt_req = halt;
    lastIf       = ifc;
    cyc++;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expState,
                             input logic [CNT_W-1:0] expStep, input logic expDone,
                             input logic [CW_WIDTH-1:0] expCw, input logic expTerr);
    compare($sformatf("c%0d %s.state", cyc, tag), 64'(bus.state), 64'(expState));
    compare($sformatf("c%0d %s.step", cyc, tag), 64'(bus.step), 64'(expStep));
    compare($sformatf("c%0d %s.done", cyc, tag), 64'(bus.instr_done), 64'(expDone));
    compare($sformatf("c%0d %s.busy", cyc, tag), 64'(bus.busy), 64'(expState != S_IF));
    compare($sformatf("c%0d %s.cw", cyc, tag), 64'(bus.control_word), 64'(expCw));
    compare($sformatf("c%0d %s.terr", cyc, tag), 64'(bus.timeout_err), 64'(expTerr));
  endtask

  // Hold reset for three cycles; the following stimulus cycle releases it.
  task automatic doReset();
    logic [CW_WIDTH-1:0] ic;
    rstLevel = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ic = randCw();
      applyStimulus(1'b1, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'($urandom));
      checkOutput("reset", S_IF, '0, 1'b0, ic & ~IL_MASK, 1'b0);
    end
    rstLevel = 1'b1;
  endtask

  // Instruction-level model: fetch latency, then the EX pattern implied by the kind.
  task automatic runInstr(input int kind, input int iters, input int fwait, input int mwait);
    logic [CW_WIDTH-1:0] ic, ec;
    int ke, n;
    for (int f = 0; f < fwait; f++) begin
      ic = randCw();
      applyStimulus(1'b0, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b0);
      checkOutput("fetch_wait", S_IF, '0, 1'b0, ic & ~IL_MASK, 1'b0);
    end
    ic = randCw();
    applyStimulus(1'b1, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b0);
    checkOutput("fetch", S_IF, '0, 1'b0, ic, 1'b0);

    ke = (kind == 3) ? 0 : kind;
    if (ke == 1) begin
      n = (iters == 0) ? 1 : iters;
      for (int s = 0; s < n; s++) begin
        ec = randCw();
        applyStimulus(1'($urandom), randCw(), ec,
                      (s == 0) ? 2'(kind) : 2'($urandom),
                      (s == 0) ? CNT_W'(iters) : CNT_W'($urandom), 1'($urandom));
        checkOutput((s == 0) ? "ex0_iter" : "exn", (s == 0) ? S_EX0 : S_EXN,
                    CNT_W'(s), s == n - 1, ec, 1'b0);
      end
    end else if (ke == 2) begin
      for (int j = 0; j <= mwait; j++) begin
        ec = randCw();
        applyStimulus(j == mwait, randCw(), ec, (j == 0) ? 2'(kind) : 2'($urandom),
                      CNT_W'($urandom), 1'($urandom));
        checkOutput((j == 0) ? "ex0_mem" : "memw", (j == 0) ? S_EX0 : S_MEMW, '0,
                    j == mwait, (j == mwait) ? ec : (ec & ~RW_MASK), 1'b0);
      end
    end else begin
      ec = randCw();
      applyStimulus(1'($urandom), randCw(), ec, 2'(kind), CNT_W'($urandom), 1'($urandom));
      checkOutput("ex0_single", S_EX0, '0, 1'b1, ec, 1'b0);
    end
  endtask

  // HALT is terminal: whatever the inputs, the sequencer stays put.
  task automatic checkHalted(input string tag, input logic expTerr, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b1, randCw(), randCw(), 2'($urandom), CNT_W'($urandom), 1'($urandom));
      checkOutput(tag, S_HALT, '0, 1'b0, '0, expTerr);
    end
  endtask

  initial begin
    logic [CW_WIDTH-1:0] ic, ec;
    rstLevel = 1'b0;
    reset    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.if_cw    = '0;
    bus.ex_cw    = '0;
    bus.ex_kind  = 2'b00;
    bus.ex_iters = '0;
    bus.halt_req = 1'b0;
    lastIf       = '0;

    // Reset, then a single-cycle instruction and an illegal kind.
    doReset();
    runInstr(0, 0, 0, 0);
    runInstr(3, 0, 0, 0);

    // Long iteration and the counter ceiling.
    runInstr(1, 64, 0, 0);
    runInstr(1, 127, 1, 0);
    runInstr(1, 2, 0, 0);
    runInstr(1, 1, 0, 0);
    runInstr(1, 0, 0, 0);

    // Memory waits: none, five, and the longest tolerated window.
    runInstr(2, 0, 0, 0);
    runInstr(2, 0, 0, 5);
    runInstr(2, 0, MEM_TIMEOUT, MEM_TIMEOUT);

    // Randomised instruction mix.
    for (int i = 0; i < 25; i++) begin
      runInstr($urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 20),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_TIMEOUT) : 0,
               $urandom_range(0, MEM_TIMEOUT));
    end

    // Halt request at an instruction boundary.
    ic = randCw();
    applyStimulus(1'b1, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b1);
    checkOutput("halt_req", S_IF, '0, 1'b0, ic & ~IL_MASK, 1'b0);
    checkHalted("halted", 1'b0, 3);

    // Fetch timeout: sixteen consecutive not-ready cycles.
    doReset();
    for (int f = 0; f <= MEM_TIMEOUT; f++) begin
      ic = randCw();
      applyStimulus(1'b0, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b0);
      checkOutput("fetch_stuck", S_IF, '0, 1'b0, ic & ~IL_MASK, 1'b0);
    end
    checkHalted("fetch_timeout", 1'b1, 3);

    // Data-access timeout: EX0 plus fifteen MEMW cycles without ready.
    doReset();
    runInstr(0, 0, 0, 0);
    ic = randCw();
    applyStimulus(1'b1, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b0);
    checkOutput("fetch", S_IF, '0, 1'b0, ic, 1'b0);
    for (int j = 0; j <= MEM_TIMEOUT; j++) begin
      ec = randCw();
      applyStimulus(1'b0, randCw(), ec, 2'b10, CNT_W'($urandom), 1'b0);
      checkOutput("mem_stuck", (j == 0) ? S_EX0 : S_MEMW, '0, 1'b0, ec & ~RW_MASK, 1'b0);
    end
    checkHalted("mem_timeout", 1'b1, 2);

    // Asynchronous reset in the middle of an iteration.
    doReset();
    ic = randCw();
    applyStimulus(1'b1, ic, randCw(), 2'($urandom), CNT_W'($urandom), 1'b0);
    checkOutput("fetch", S_IF, '0, 1'b0, ic, 1'b0);
    for (int s = 0; s <= 10; s++) begin
      ec = randCw();
      applyStimulus(1'($urandom), randCw(), ec, (s == 0) ? 2'b01 : 2'($urandom),
                    (s == 0) ? CNT_W'(40) : CNT_W'($urandom), 1'($urandom));
      checkOutput((s == 0) ? "ex0_iter" : "exn", (s == 0) ? S_EX0 : S_EXN,
                  CNT_W'(s), 1'b0, ec, 1'b0);
    end
    rstLevel = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("async_reset", S_IF, '0, 1'b0, lastIf & ~IL_MASK, 1'b0);
    doReset();
    runInstr(1, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
